// File: rtl/cga_test_source.sv
// CGA raster timing and test-pattern source that feeds cga_composite directly.
// Character enables come from a 5-bit divider; all video-side outputs are registered once per character.
module cga_test_source #(
   parameter int H_TOTAL    = 57,
   parameter int H_DISP     = 40,
   parameter int H_SYNC_POS = 45,
   parameter int H_SYNC_W   = 10,
   parameter int V_TOTAL    = 262,
   parameter int V_DISP     = 200,
   parameter int V_SYNC_POS = 224,
   parameter int V_SYNC_W   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] pattern_sel,
   input  logic [3:0] solid_color,
   input  logic [3:0] border_color,
   input  logic       intensity,
   output logic       hclk,
   output logic       lclk,
   output logic       hsync,
   output logic       vsync_l,
   output logic [3:0] video,
   output logic       display_en,
   output logic       frame_start
);

   localparam logic [5:0] H_LAST  = 6'(H_TOTAL - 1);
   localparam logic [5:0] H_DLIM  = 6'(H_DISP);
   localparam logic [5:0] H_SLO   = 6'(H_SYNC_POS);
   localparam logic [5:0] H_SHI   = 6'(H_SYNC_POS + H_SYNC_W);
   localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
   localparam logic [8:0] V_DLIM  = 9'(V_DISP);
   localparam logic [8:0] V_SLO   = 9'(V_SYNC_POS);
   localparam logic [8:0] V_SHI   = 9'(V_SYNC_POS + V_SYNC_W);

   logic [4:0] div;
   logic [5:0] hcnt, hcnt_n;
   logic [8:0] vcnt, vcnt_n;
   logic [2:0] sub, sub_n, bar_idx, bar_idx_n;
   logic [1:0] pat_q, pat_eff;
   logic [3:0] solid_q, solid_eff;
   logic       int_q, int_eff;
   logic       h_wrap, frame_wrap;
   logic       hsync_n, vsync_n, disp_n;
   logic [3:0] video_n;

   assign hclk = div[3];
   assign lclk = (div == 5'd31);

   always_comb begin
      h_wrap     = (hcnt == H_LAST);
      frame_wrap = h_wrap && (vcnt == V_LAST);
      hcnt_n     = h_wrap ? 6'd0 : hcnt + 6'd1;
      vcnt_n     = vcnt;
      if (h_wrap)
         vcnt_n = (vcnt == V_LAST) ? 9'd0 : vcnt + 9'd1;

      // bar_idx tracks hcnt_next/5 without a divider
      sub_n     = sub + 3'd1;
      bar_idx_n = bar_idx;
      if (h_wrap) begin
         sub_n     = 3'd0;
         bar_idx_n = 3'd0;
      end else if (sub == 3'd4) begin
         sub_n     = 3'd0;
         bar_idx_n = bar_idx + 3'd1;
      end

      // The frame's first character already uses the freshly sampled inputs
      pat_eff   = frame_wrap ? pattern_sel : pat_q;
      solid_eff = frame_wrap ? solid_color : solid_q;
      int_eff   = frame_wrap ? intensity   : int_q;

      hsync_n = (hcnt_n >= H_SLO) && (hcnt_n < H_SHI);
      vsync_n = (vcnt_n >= V_SLO) && (vcnt_n < V_SHI);
      disp_n  = (hcnt_n < H_DLIM) && (vcnt_n < V_DLIM);

      video_n = border_color;
      if (disp_n) begin
         case (pat_eff)
            2'd0:    video_n = {int_eff, ~bar_idx_n};
            2'd1:    video_n = ((hcnt_n[2:0] == 3'd0) || (vcnt_n[3:0] == 4'd0))
                               ? {int_eff, 3'b111} : 4'b0000;
            2'd2:    video_n = solid_eff;
            default: video_n = border_color;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div         <= 5'd0;
         hcnt        <= 6'd0;
         vcnt        <= 9'd0;
         sub         <= 3'd0;
         bar_idx     <= 3'd0;
         pat_q       <= 2'd3;
         solid_q     <= 4'd0;
         int_q       <= 1'b0;
         hsync       <= 1'b0;
         vsync_l     <= 1'b0;
         display_en  <= 1'b0;
         video       <= 4'd0;
         frame_start <= 1'b0;
      end else begin
         div         <= div + 5'd1;
         frame_start <= lclk && frame_wrap;
         if (lclk) begin
            hcnt       <= hcnt_n;
            vcnt       <= vcnt_n;
            sub        <= sub_n;
            bar_idx    <= bar_idx_n;
            hsync      <= hsync_n;
            vsync_l    <= vsync_n;
            display_en <= disp_n;
            video      <= video_n;
            if (frame_wrap) begin
               pat_q   <= pattern_sel;
               solid_q <= solid_color;
               int_q   <= intensity;
            end
         end
      end
   end

endmodule

// File: tb/tb_cga_test_source.sv
// Directed bench for cga_test_source; vertical timing is shortened so several frames fit in a short run.
module tb_cga_test_source;

   localparam int LINE  = 57 * 32;
   localparam int FRAME = 7 * LINE;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] pattern_sel = 2'd0;
   logic [3:0] solid_color = 4'hC;
   logic [3:0] border_color = 4'h1;
   logic       intensity = 1'b1;
   logic       hclk, lclk, hsync, vsync_l, display_en, frame_start;
   logic [3:0] video;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   cga_test_source #(
      .V_TOTAL(7), .V_DISP(3), .V_SYNC_POS(4), .V_SYNC_W(2)
   ) dut (
      .clk(clk), .reset(reset), .pattern_sel(pattern_sel),
      .solid_color(solid_color), .border_color(border_color),
      .intensity(intensity), .hclk(hclk), .lclk(lclk), .hsync(hsync),
      .vsync_l(vsync_l), .video(video), .display_en(display_en),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic goto(input int k);
      while (cyc < k) step();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      cyc = 0;
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (lclk !== ((cyc == 31) || (cyc == 63))) begin
            errors++;
            $display("FAIL reset_lclk cyc=%0d got=%b", cyc, lclk);
         end
         checks++;
         if (hclk !== 1'((cyc >> 3) & 1)) begin
            errors++;
            $display("FAIL reset_hclk cyc=%0d got=%b", cyc, hclk);
         end
         if (cyc < 32) begin
            checks++;
            if ({video, hsync, vsync_l, display_en, frame_start} !== 8'h00) begin
               errors++;
               $display("FAIL reset_outputs cyc=%0d got video=%h hs=%b vs=%b de=%b fs=%b want all 0",
                        cyc, video, hsync, vsync_l, display_en, frame_start);
            end
         end else if (cyc == 32) begin
            checks++;
            if (video !== 4'h1 || display_en !== 1'b1) begin
               errors++;
               $display("FAIL reset_first_char got video=%h de=%b want 1/1", video, display_en);
            end
         end
         step();
      end
   endtask

   task automatic test_hsync_line();
      int rise1 = -1, rise2 = -1, cnt = 0;
      logic prev = hsync;
      while (cyc < LINE + 1500) begin
         step();
         if (hsync && !prev) begin
            if (rise1 < 0) rise1 = cyc;
            else if (rise2 < 0) rise2 = cyc;
         end
         if (hsync && cyc < LINE) cnt++;
         prev = hsync;
      end
      checks++;
      if (rise1 !== 1440) begin
         errors++;
         $display("FAIL hsync_start got=%0d want=1440", rise1);
      end
      checks++;
      if (cnt !== 320) begin
         errors++;
         $display("FAIL hsync_width got=%0d want=320", cnt);
      end
      checks++;
      if (rise2 - rise1 !== LINE) begin
         errors++;
         $display("FAIL line_period got=%0d want=%0d", rise2 - rise1, LINE);
      end
   endtask

   task automatic test_frame();
      int vrise = -1, vcnt_hi = 0, fs_first = -1, fs_cnt = 0;
      logic prev = vsync_l;
      while (cyc < FRAME + 2) begin
         step();
         if (vsync_l && !prev && vrise < 0) vrise = cyc;
         if (vsync_l) vcnt_hi++;
         if (frame_start) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = cyc;
         end
         prev = vsync_l;
         if (cyc == LINE + 5*32 + 16) begin
            checks++;
            if (video !== 4'h1) begin
               errors++;
               $display("FAIL first_frame_border got=%h want=1", video);
            end
         end
         if (cyc == 2*LINE + 39*32 + 16) begin
            checks++;
            if (display_en !== 1'b1) begin
               errors++;
               $display("FAIL de_last_active got=%b want=1", display_en);
            end
         end
         if (cyc == 3*LINE + 16) begin
            checks++;
            if (display_en !== 1'b0) begin
               errors++;
               $display("FAIL de_below_active got=%b want=0", display_en);
            end
         end
      end
      checks++;
      if (vrise !== 4*LINE) begin
         errors++;
         $display("FAIL vsync_start got=%0d want=%0d", vrise, 4*LINE);
      end
      checks++;
      if (vcnt_hi !== 2*LINE) begin
         errors++;
         $display("FAIL vsync_width got=%0d want=%0d", vcnt_hi, 2*LINE);
      end
      checks++;
      if (fs_first !== FRAME || fs_cnt !== 1) begin
         errors++;
         $display("FAIL frame_start got first=%0d count=%0d want %0d/1", fs_first, fs_cnt, FRAME);
      end
   endtask

   task automatic test_bars();
      int         chr [8] = '{0, 4, 5, 20, 35, 39, 40, 50};
      logic [3:0] exp [8] = '{4'hF, 4'hF, 4'hE, 4'hB, 4'h8, 4'h8, 4'h1, 4'h1};
      for (int i = 0; i < 8; i++) begin
         goto(FRAME + chr[i]*32 + 16);
         checks++;
         if (video !== exp[i]) begin
            errors++;
            $display("FAIL bars_char%0d got=%h want=%h", chr[i], video, exp[i]);
         end
      end
      goto(FRAME + LINE + 16);
      pattern_sel = 2'd2;
      goto(FRAME + 2*LINE + 16);
      checks++;
      if (video !== 4'hF) begin
         errors++;
         $display("FAIL bars_held_midframe got=%h want=F", video);
      end
      for (int c = 0; c < 40; c += 20) begin
         goto(FRAME + 3*LINE + c*32 + 16);
         checks++;
         if (video !== 4'h1) begin
            errors++;
            $display("FAIL bars_below_active char%0d got=%h want=1", c, video);
         end
      end
   endtask

   task automatic test_solid();
      int         chr [3] = '{0, 39, 40};
      logic [3:0] exp [3] = '{4'hC, 4'hC, 4'h1};
      goto(2*FRAME);
      checks++;
      if (frame_start !== 1'b1) begin
         errors++;
         $display("FAIL solid_frame_start got=%b want=1", frame_start);
      end
      for (int i = 0; i < 3; i++) begin
         goto(2*FRAME + chr[i]*32 + 16);
         checks++;
         if (video !== exp[i]) begin
            errors++;
            $display("FAIL solid_char%0d got=%h want=%h", chr[i], video, exp[i]);
         end
      end
      goto(2*FRAME + LINE + 16);
      pattern_sel = 2'd1;
      intensity   = 1'b0;
      solid_color = 4'h3;
      goto(2*FRAME + 2*LINE + 20*32 + 16);
      checks++;
      if (video !== 4'hC) begin
         errors++;
         $display("FAIL solid_held_midframe got=%h want=C", video);
      end
   endtask

   task automatic test_grid();
      int         ln  [6] = '{0, 1, 1, 1, 1, 2};
      int         chr [6] = '{1, 0, 3, 8, 39, 16};
      logic [3:0] exp [6] = '{4'h7, 4'h7, 4'h0, 4'h7, 4'h0, 4'h7};
      for (int i = 0; i < 6; i++) begin
         goto(3*FRAME + ln[i]*LINE + chr[i]*32 + 16);
         checks++;
         if (video !== exp[i]) begin
            errors++;
            $display("FAIL grid_l%0d_c%0d got=%h want=%h", ln[i], chr[i], video, exp[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      goto(3*FRAME + 5*LINE + 50*32 + 16);
      checks++;
      if (hsync !== 1'b1 || vsync_l !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_sync got hs=%b vs=%b want 1/1", hsync, vsync_l);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cyc = 0;
      checks++;
      if ({video, hsync, vsync_l, display_en, lclk, hclk} !== 9'h000) begin
         errors++;
         $display("FAIL mid_reset_outputs got video=%h hs=%b vs=%b de=%b lclk=%b hclk=%b want all 0",
                  video, hsync, vsync_l, display_en, lclk, hclk);
      end
      goto(48);
      checks++;
      if (video !== 4'h1 || display_en !== 1'b1 || vsync_l !== 1'b0) begin
         errors++;
         $display("FAIL restart_char1 got video=%h de=%b vs=%b want 1/1/0", video, display_en, vsync_l);
      end
      goto(LINE + 20*32 + 16);
      checks++;
      if (video !== 4'h1) begin
         errors++;
         $display("FAIL restart_pattern3 got=%h want=1", video);
      end
   endtask

   initial begin
      test_reset();
      test_hsync_line();
      test_frame();
      test_bars();
      test_solid();
      test_grid();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
